// File: rtl/lb_arb2.sv
// lb_arb2: two-master local-bus arbiter with one-deep holding slots, round-robin
// issue and a read-owner tag pipe. Define LB_ARB_STATS_EN for per-master issue counters.
module lb_arb2 #(
  parameter int AW       = 24,
  parameter int DW       = 32,
  parameter int READ_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_dout,
  input  logic          m0_rd,
  input  logic          m0_strobe,
  output logic [DW-1:0] m0_din,
  output logic          m0_rvalid,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_dout,
  input  logic          m1_rd,
  input  logic          m1_strobe,
  output logic [DW-1:0] m1_din,
  output logic          m1_rvalid,
  output logic [AW-1:0] lb_addr,
  output logic [DW-1:0] lb_dout,
  output logic          lb_rd,
  output logic          lb_strobe,
  input  logic [DW-1:0] lb_din,
  output logic [1:0]    overflow,
`ifdef LB_ARB_STATS_EN
  output logic [15:0]   m0_count,
  output logic [15:0]   m1_count,
`endif
  input  logic          clr_overflow
);

  // Masters strobe without back-pressure: a strobe is always taken, either issued,
  // parked in the slot, or dropped and flagged in overflow when the slot is occupied.
  logic [1:0]    strobe;
  logic [1:0]    rd;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] dout [2];

  assign strobe  = {m1_strobe, m0_strobe};
  assign rd      = {m1_rd, m0_rd};
  assign addr[0] = m0_addr;
  assign addr[1] = m1_addr;
  assign dout[0] = m0_dout;
  assign dout[1] = m1_dout;

  logic [1:0]    slot_v_q, slot_v_d;
  logic [1:0]    slot_rd_q, slot_rd_d;
  logic [AW-1:0] slot_addr_q [2];
  logic [AW-1:0] slot_addr_d [2];
  logic [DW-1:0] slot_dout_q [2];
  logic [DW-1:0] slot_dout_d [2];

  logic [1:0]    cand_v;
  logic [1:0]    cand_rd;
  logic [AW-1:0] cand_addr [2];
  logic [DW-1:0] cand_dout [2];

  logic          issue;
  logic          gnt;
  logic [1:0]    issued;
  logic [1:0]    drop;
  logic          last_grant_q, last_grant_d;

  logic          lb_strobe_q, lb_strobe_d;
  logic          lb_rd_q, lb_rd_d;
  logic [AW-1:0] lb_addr_q, lb_addr_d;
  logic [DW-1:0] lb_dout_q, lb_dout_d;
  logic          lb_owner_q, lb_owner_d;

  logic [READ_LAT-1:0] tag_v_q, tag_v_d;
  logic [READ_LAT-1:0] tag_own_q, tag_own_d;
  logic [1:0]          rvalid;
  logic [DW-1:0]       din_hold_q [2];
  logic [DW-1:0]       din_hold_d [2];
  logic [1:0]          ovf_q, ovf_d;

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      cand_v[n]    = slot_v_q[n] | strobe[n];
      cand_rd[n]   = slot_v_q[n] ? slot_rd_q[n]   : rd[n];
      cand_addr[n] = slot_v_q[n] ? slot_addr_q[n] : addr[n];
      cand_dout[n] = slot_v_q[n] ? slot_dout_q[n] : dout[n];
    end
    issue = |cand_v;
    // On a tie the master not granted last wins; otherwise the lone candidate goes.
    if (&cand_v) gnt = ~last_grant_q;
    else         gnt = cand_v[1];
    issued       = issue ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    last_grant_d = issue ? gnt : last_grant_q;
  end

  always_comb begin
    slot_v_d    = slot_v_q;
    slot_rd_d   = slot_rd_q;
    slot_addr_d = slot_addr_q;
    slot_dout_d = slot_dout_q;
    drop        = 2'b00;
    for (int n = 0; n < 2; n++) begin
      if (issued[n]) slot_v_d[n] = 1'b0;
      // A new strobe may enter the slot only if the slot is free after this edge
      // and the strobe itself was not the one issued.
      if (strobe[n]) begin
        if ((slot_v_q[n] && issued[n]) || (!slot_v_q[n] && !issued[n])) begin
          slot_v_d[n]    = 1'b1;
          slot_rd_d[n]   = rd[n];
          slot_addr_d[n] = addr[n];
          slot_dout_d[n] = dout[n];
        end else if (slot_v_q[n] && !issued[n]) begin
          drop[n] = 1'b1;
        end
      end
    end
    ovf_d = (clr_overflow ? 2'b00 : ovf_q) | drop;
  end

  always_comb begin
    lb_strobe_d = issue;
    lb_rd_d     = issue & cand_rd[gnt];
    lb_addr_d   = issue ? cand_addr[gnt] : lb_addr_q;
    lb_dout_d   = issue ? cand_dout[gnt] : lb_dout_q;
    lb_owner_d  = issue ? gnt : lb_owner_q;
  end

  // The tag pipe starts from the registered bus strobe, so its tail lines up with
  // lb_din exactly READ_LAT cycles after the read is on the bus.
  always_comb begin
    tag_v_d      = tag_v_q;
    tag_own_d    = tag_own_q;
    tag_v_d[0]   = lb_strobe_q & lb_rd_q;
    tag_own_d[0] = lb_owner_q;
    for (int i = 1; i < READ_LAT; i++) begin
      tag_v_d[i]   = tag_v_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  assign rvalid[0] = tag_v_q[READ_LAT-1] & ~tag_own_q[READ_LAT-1];
  assign rvalid[1] = tag_v_q[READ_LAT-1] &  tag_own_q[READ_LAT-1];

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      din_hold_d[n] = rvalid[n] ? lb_din : din_hold_q[n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v_q     <= 2'b00;
      slot_rd_q    <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        slot_addr_q[n] <= '0;
        slot_dout_q[n] <= '0;
        din_hold_q[n]  <= '0;
      end
      last_grant_q <= 1'b1;
      lb_strobe_q  <= 1'b0;
      lb_rd_q      <= 1'b0;
      lb_addr_q    <= '0;
      lb_dout_q    <= '0;
      lb_owner_q   <= 1'b0;
      tag_v_q      <= '0;
      tag_own_q    <= '0;
      ovf_q        <= 2'b00;
    end else begin
      slot_v_q     <= slot_v_d;
      slot_rd_q    <= slot_rd_d;
      slot_addr_q  <= slot_addr_d;
      slot_dout_q  <= slot_dout_d;
      din_hold_q   <= din_hold_d;
      last_grant_q <= last_grant_d;
      lb_strobe_q  <= lb_strobe_d;
      lb_rd_q      <= lb_rd_d;
      lb_addr_q    <= lb_addr_d;
      lb_dout_q    <= lb_dout_d;
      lb_owner_q   <= lb_owner_d;
      tag_v_q      <= tag_v_d;
      tag_own_q    <= tag_own_d;
      ovf_q        <= ovf_d;
    end
  end

  assign lb_strobe = lb_strobe_q;
  assign lb_rd     = lb_rd_q;
  assign lb_addr   = lb_addr_q;
  assign lb_dout   = lb_dout_q;
  assign overflow  = ovf_q;
  assign m0_rvalid = rvalid[0];
  assign m1_rvalid = rvalid[1];
  assign m0_din    = rvalid[0] ? lb_din : din_hold_q[0];
  assign m1_din    = rvalid[1] ? lb_din : din_hold_q[1];

`ifdef LB_ARB_STATS_EN
  logic [15:0] cnt_q [2];
  logic [15:0] cnt_d [2];

  // Saturating issue counters; clr_overflow takes precedence over an increment.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      if (clr_overflow)                          cnt_d[n] = 16'd0;
      else if (issued[n] && cnt_q[n] != 16'hFFFF) cnt_d[n] = cnt_q[n] + 16'd1;
      else                                       cnt_d[n] = cnt_q[n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q[0] <= 16'd0;
      cnt_q[1] <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign m0_count = cnt_q[0];
  assign m1_count = cnt_q[1];
`endif

endmodule

// File: tb/tb_lb_arb2.sv
// tb_lb_arb2: randomized bench for lb_arb2 with a queue-based reference model,
// a bus responder and a monitor that scores bus transactions and read returns.
module tb_lb_arb2;
  localparam int AW       = 24;
  localparam int DW       = 32;
  localparam int READ_LAT = 2;
  localparam int RW       = 1 + AW + DW;
  localparam int EW       = 32 + RW;

  typedef struct packed {
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
  } req_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_dout = '0, m1_dout = '0;
  logic          m0_rd = 1'b0, m1_rd = 1'b0;
  logic          m0_strobe = 1'b0, m1_strobe = 1'b0;
  logic [DW-1:0] m0_din, m1_din;
  logic          m0_rvalid, m1_rvalid;
  logic [AW-1:0] lb_addr;
  logic [DW-1:0] lb_dout;
  logic          lb_rd, lb_strobe;
  logic [DW-1:0] lb_din = '0;
  logic [1:0]    overflow;
  logic          clr_overflow = 1'b0;
`ifdef LB_ARB_STATS_EN
  logic [15:0]   m0_count, m1_count;
`endif

  lb_arb2 #(.AW(AW), .DW(DW), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_dout(m0_dout), .m0_rd(m0_rd), .m0_strobe(m0_strobe),
    .m0_din(m0_din), .m0_rvalid(m0_rvalid),
    .m1_addr(m1_addr), .m1_dout(m1_dout), .m1_rd(m1_rd), .m1_strobe(m1_strobe),
    .m1_din(m1_din), .m1_rvalid(m1_rvalid),
    .lb_addr(lb_addr), .lb_dout(lb_dout), .lb_rd(lb_rd), .lb_strobe(lb_strobe),
    .lb_din(lb_din), .overflow(overflow),
`ifdef LB_ARB_STATS_EN
    .m0_count(m0_count), .m1_count(m1_count),
`endif
    .clr_overflow(clr_overflow)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] bus_data(input logic [AW-1:0] a);
    case (a)
      24'd0:   return 32'h48656c6c;
      24'd1:   return 32'h6f20776f;
      24'd2:   return 32'h726c6421;
      default: return {a[7:0], a} ^ 32'h5a5a5a5a;
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Each master owns a request queue that may hold at most one request between
  // edges; the bus takes one request per cycle, alternating on contention.
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] rsp_q0[$];
  logic [DW-1:0] rsp_q1[$];
  req_t          pend0[$];
  req_t          pend1[$];
  bit            m_last = 1'b1;
  logic [1:0]    m_ovf = 2'b00;
  int            m_cnt[2];
  logic [DW-1:0] hold0 = '0, hold1 = '0;
  logic [DW-1:0] sched[int];

  task automatic model_step(input bit s0, input req_t q0, input bit s1, input req_t q1, input bit clr);
    req_t r;
    bit   g;
    bit   h0, h1;
    if (s0) pend0.push_back(q0);
    if (s1) pend1.push_back(q1);
    h0 = pend0.size() > 0;
    h1 = pend1.size() > 0;
    if (h0 || h1) begin
      g = (h0 && h1) ? ~m_last : h1;
      if (g) r = pend1.pop_front();
      else   r = pend0.pop_front();
      m_last = g;
      exp_q.push_back({32'(cyc + 1), r});
      if (r.rd) begin
        if (g) rsp_q1.push_back(bus_data(r.addr));
        else   rsp_q0.push_back(bus_data(r.addr));
      end
      if (m_cnt[g] < 65535) m_cnt[g]++;
    end
    if (clr) begin
      m_ovf = 2'b00;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
    end
    if (pend0.size() > 1) begin void'(pend0.pop_back()); m_ovf[0] = 1'b1; end
    if (pend1.size() > 1) begin void'(pend1.pop_back()); m_ovf[1] = 1'b1; end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit s0, input bit r0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit s1, input bit r1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input bit c);
    @(posedge clk);
    #1;
    check("overflow", overflow, m_ovf);
`ifdef LB_ARB_STATS_EN
    check("m0_count", m0_count, m_cnt[0]);
    check("m1_count", m1_count, m_cnt[1]);
`endif
    m0_strobe = s0; m0_rd = r0; m0_addr = a0; m0_dout = d0;
    m1_strobe = s1; m1_rd = r1; m1_addr = a1; m1_dout = d1;
    clr_overflow = c;
    model_step(s0, {r0, a0, d0}, s1, {r1, a1, d1}, c);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    m0_strobe = 1'b0; m1_strobe = 1'b0; clr_overflow = 1'b0;
    exp_q.delete(); rsp_q0.delete(); rsp_q1.delete();
    pend0.delete(); pend1.delete(); sched.delete();
    m_last = 1'b1; m_ovf = 2'b00; m_cnt[0] = 0; m_cnt[1] = 0;
    hold0 = '0; hold1 = '0;
    #1;
    check("rst_lb_strobe", lb_strobe, 0);
    check("rst_lb_rd", lb_rd, 0);
    check("rst_lb_addr", lb_addr, 0);
    check("rst_lb_dout", lb_dout, 0);
    check("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
    check("rst_m0_din", m0_din, 0);
    check("rst_m1_din", m1_din, 0);
    check("rst_overflow", overflow, 0);
`ifdef LB_ARB_STATS_EN
    check("rst_m0_count", m0_count, 0);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- bus responder ----------------
  always @(posedge clk) begin
    #1;
    if (sched.exists(cyc)) begin
      lb_din = sched[cyc];
      sched.delete(cyc);
    end else begin
      lb_din = $urandom;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    req_t          er;
    logic [DW-1:0] x;
    if (rst_n) begin
      if (lb_strobe) begin
        if (lb_rd) sched[cyc + READ_LAT] = bus_data(lb_addr);
        if (exp_q.size() == 0) begin
          check("bus_unexpected_strobe", 1, 0);
        end else begin
          e  = exp_q.pop_front();
          er = e[RW-1:0];
          check("bus_cycle", cyc, e[EW-1 -: 32]);
          check("bus_rd", lb_rd, er.rd);
          check("bus_addr", lb_addr, er.addr);
          if (!er.rd) check("bus_dout", lb_dout, er.dout);
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) <= cyc) begin
        e = exp_q.pop_front();
        check("bus_missing_strobe", 0, 1);
      end
      if (m0_rvalid) begin
        if (rsp_q0.size() == 0) check("m0_unexpected_rvalid", 1, 0);
        else begin x = rsp_q0.pop_front(); check("m0_din", m0_din, x); hold0 = x; end
      end else begin
        check("m0_din_hold", m0_din, hold0);
      end
      if (m1_rvalid) begin
        if (rsp_q1.size() == 0) check("m1_unexpected_rvalid", 1, 0);
        else begin x = rsp_q1.pop_front(); check("m1_din", m1_din, x); hold1 = x; end
      end else begin
        check("m1_din_hold", m1_din, hold1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int p;
    do_reset();

    // simultaneous reads straight out of reset: m0 wins the first tie
    drive(1, 1, 24'd0, '0, 1, 1, 24'd1, '0, 0);
    idle(5);

    // fairness: one tie, then strobes alternate so the bus stays saturated
    drive(1, 0, 24'h000100, $urandom, 1, 0, 24'h800100, $urandom, 0);
    for (int i = 1; i < 20; i++) begin
      if (i % 2 == 1) drive(1, $urandom_range(0, 1), 24'h000100 + 24'(i), $urandom, 0, 0, '0, '0, 0);
      else            drive(0, 0, '0, '0, 1, $urandom_range(0, 1), 24'h800100 + 24'(i), $urandom, 0);
    end
    idle(4);
    @(negedge clk);
    check("fair_overflow", overflow, 2'b00);

    // single read of "rld!"
    drive(1, 1, 24'd2, '0, 0, 0, '0, '0, 0);
    idle(5);

    // write from m1
    drive(0, 0, '0, '0, 1, 0, 24'd3, 32'hDEADBEEF, 0);
    idle(4);

    // overflow: last grant is m1, so m1 loses the first tie and one m1 strobe drops
    for (int i = 0; i < 3; i++)
      drive(1, 1, 24'h000010 + 24'(i), '0, 1, 1, 24'h800010 + 24'(i), '0, 0);
    idle(3);
    @(negedge clk);
    check("ovf_set", overflow, 2'b10);
    drive(0, 0, '0, '0, 0, 0, '0, '0, 1);
    idle(1);
    @(negedge clk);
    check("ovf_clr", overflow, 2'b00);

    // randomized traffic at three densities with occasional clears
    foreach (p_tab[k]) begin
      p = p_tab[k];
      for (int i = 0; i < 150; i++) begin
        drive($urandom_range(0, 99) < p, $urandom_range(0, 1), {1'b0, 23'($urandom)}, $urandom,
              $urandom_range(0, 99) < p, $urandom_range(0, 1), {1'b1, 23'($urandom)}, $urandom,
              $urandom_range(0, 19) == 0);
      end
    end
    idle(READ_LAT + 4);

    // reset one cycle after a read reaches the bus
    drive(1, 1, 24'd5, '0, 0, 0, '0, '0, 0);
    idle(1);
    do_reset();
    idle(READ_LAT + 6);

    check("exp_q_drained", exp_q.size(), 0);
    check("rsp_q0_drained", rsp_q0.size(), 0);
    check("rsp_q1_drained", rsp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  int p_tab[3] = '{30, 60, 90};

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
